// File: rtl/fetch_pkg.sv
// Shared constants, opcode encodings and FSM state type for the fetch stage.
// The FETCH_BTFN_EN macro (see fetch_unit) selects static backward-taken prediction.
package fetch_pkg;

    localparam int          FETCH_PC_W     = 32;
    localparam logic [31:0] FETCH_NOP_WORD = 32'h0000_0000;

    // Opcode lives in instr[31:26], branch displacement in instr[15:0].
    localparam logic [5:0] OP_BEQ = 6'b100000;
    localparam logic [5:0] OP_BNE = 6'b100001;
    localparam logic [5:0] OP_BLT = 6'b100010;
    localparam logic [5:0] OP_BLE = 6'b100011;
    localparam logic [5:0] OP_J   = 6'b000010;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    function automatic logic is_cond_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_BLE);
    endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational predecode of the word returned by IMem: flags backward conditional
// branches and computes their target (pc + 1 + sext(imm16)). Used only with FETCH_BTFN_EN.
module fetch_predecode
    import fetch_pkg::*;
#(
    parameter int PC_W = FETCH_PC_W
) (
    input  logic [31:0]     i_instr,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_is_bwd_branch,
    output logic [PC_W-1:0] o_target
);

    logic [5:0]  w_opcode;
    logic [15:0] w_imm;
    logic        w_unused_bits;

    assign w_opcode      = i_instr[31:26];
    assign w_imm         = i_instr[15:0];
    assign w_unused_bits = ^i_instr[25:16];

    assign o_is_bwd_branch = is_cond_branch(w_opcode) && w_imm[15];
    // PC_W is assumed wider than the 16-bit displacement.
    assign o_target        = i_pc + PC_W'(1) + {{(PC_W-16){w_imm[15]}}, w_imm};

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the word PC, captures IMem data into IF/ID, handles
// decode stalls and downstream redirects. Define FETCH_BTFN_EN for backward-taken prediction.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = FETCH_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_WORD = FETCH_NOP_WORD
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_pc,
    input  logic [31:0]     imem_instr,
    input  logic            id_ready,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [31:0]     if_id_instr,
    output logic [PC_W-1:0] if_id_pc,
    output logic            if_id_pred_taken,
    output logic [31:0]     fetch_count
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_next_pc;
    logic            r_if_id_valid;
    logic [31:0]     r_if_id_instr;
    logic [PC_W-1:0] r_if_id_pc;
    logic            r_if_id_pred;
    logic [31:0]     r_fetch_count;
    logic            w_advance;
    logic            w_pred;

`ifdef FETCH_BTFN_EN
    logic            w_is_bwd;
    logic [PC_W-1:0] w_target;

    fetch_predecode #(
        .PC_W (PC_W)
    ) u_predecode (
        .i_instr         (imem_instr),
        .i_pc            (r_pc),
        .o_is_bwd_branch (w_is_bwd),
        .o_target        (w_target)
    );

    assign w_pred    = w_is_bwd;
    assign w_next_pc = w_is_bwd ? w_target : r_pc + PC_W'(1);
`else
    assign w_pred    = 1'b0;
    assign w_next_pc = r_pc + PC_W'(1);
`endif

    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN: begin
                if (r_if_id_valid && !id_ready) begin
                    w_state_next = ST_HOLD;
                end else begin
                    w_advance = 1'b1;
                end
            end
            ST_HOLD: begin
                if (id_ready) begin
                    w_advance    = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_BOOT;
        endcase
        // A redirect overrides stalls and the boot cycle.
        if (redirect_valid) begin
            w_advance    = 1'b0;
            w_state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= NOP_WORD;
            r_if_id_pc    <= '0;
            r_if_id_pred  <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (redirect_valid) begin
                r_pc          <= redirect_pc;
                r_if_id_valid <= 1'b0;
                r_if_id_instr <= NOP_WORD;
                r_if_id_pred  <= 1'b0;
            end else if (w_advance) begin
                r_pc          <= w_next_pc;
                r_if_id_valid <= 1'b1;
                r_if_id_instr <= imem_instr;
                r_if_id_pc    <= r_pc;
                r_if_id_pred  <= w_pred;
                if (r_fetch_count != 32'hFFFF_FFFF) begin
                    r_fetch_count <= r_fetch_count + 32'd1;
                end
            end
        end
    end

    assign imem_pc          = r_pc;
    assign if_id_valid      = r_if_id_valid;
    assign if_id_instr      = r_if_id_instr;
    assign if_id_pc         = r_if_id_pc;
    assign if_id_pred_taken = r_if_id_pred;
    assign fetch_count      = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus randomized stalls/redirects,
// with the delivered instruction stream checked against a program-order model.
module tb_fetch_unit;

`ifdef FETCH_BTFN_EN
    localparam bit BTFN = 1'b1;
`else
    localparam bit BTFN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        id_ready = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_pred_taken;
    logic [31:0] fetch_count;

    logic [31:0] w_imem_pc;
    logic [31:0] w_imem_instr;
    logic        w_if_id_valid;
    logic [31:0] w_if_id_instr;
    logic [31:0] w_if_id_pc;
    logic        w_if_id_pred_taken;
    logic [31:0] w_fetch_count;

    logic [31:0] mem [0:63];
    int          mem_mode = 0;

    int          n_checks = 0;
    int          n_fails = 0;
    int          delivered = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] redir_q[$];

    always #5 clk = ~clk;

    // IMem model: word == address, or a small random program image.
    always @* imem_instr = (mem_mode == 0) ? imem_pc : mem[imem_pc[5:0]];
    assign w_imem_instr = w_imem_pc;

    fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .imem_pc          (imem_pc),
        .imem_instr       (imem_instr),
        .id_ready         (id_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .if_id_valid      (if_id_valid),
        .if_id_instr      (if_id_instr),
        .if_id_pc         (if_id_pc),
        .if_id_pred_taken (if_id_pred_taken),
        .fetch_count      (fetch_count)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut_w (
        .clk              (clk),
        .rst              (rst),
        .imem_pc          (w_imem_pc),
        .imem_instr       (w_imem_instr),
        .id_ready         (1'b1),
        .redirect_valid   (1'b0),
        .redirect_pc      (32'h0),
        .if_id_valid      (w_if_id_valid),
        .if_id_instr      (w_if_id_instr),
        .if_id_pc         (w_if_id_pc),
        .if_id_pred_taken (w_if_id_pred_taken),
        .fetch_count      (w_fetch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] pc);
        return (mem_mode == 0) ? pc : mem[pc[5:0]];
    endfunction

    // Backward conditional branch: BEQ/BNE/BLT/BLE with negative displacement.
    function automatic logic model_bwd(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        return BTFN && (op == 6'b100000 || op == 6'b100001 || op == 6'b100010 || op == 6'b100011)
               && w[15];
    endfunction

    function automatic logic [31:0] model_succ(input logic [31:0] pc);
        logic [31:0] w;
        w = model_word(pc);
        if (model_bwd(w)) return pc + 32'd1 + {{16{w[15]}}, w[15:0]};
        return pc + 32'd1;
    endfunction

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        redir_q.push_back(target);
    endtask

    // Monitor: every instruction decode accepts must follow program order.
    always @(negedge clk) begin
        if (rst) begin
            exp_pc = 32'h0;
            redir_q.delete();
        end else begin
            if (if_id_valid && id_ready) begin
                check("deliver_pc", if_id_pc, exp_pc);
                check("deliver_instr", if_id_instr, model_word(exp_pc));
                check("deliver_pred", 32'(if_id_pred_taken), 32'(model_bwd(model_word(exp_pc))));
                delivered++;
                exp_pc = model_succ(exp_pc);
            end
            if (redirect_valid) begin
                if (redir_q.size() == 0) begin
                    check("redir_queue_nonempty", 32'd0, 32'd1);
                end else begin
                    exp_pc = redir_q.pop_front();
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(if_id_valid), 32'd0);
        check("rst_instr", if_id_instr, 32'h0);
        check("rst_pc", if_id_pc, 32'h0);
        check("rst_pred", 32'(if_id_pred_taken), 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_imem_pc", imem_pc, 32'h0);
        check("rst_w_imem_pc", w_imem_pc, 32'hFFFF_FFFF);

        // Sequential fetch after the boot bubble.
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("boot_bubble", 32'(if_id_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("seq_pc", if_id_pc, 32'(i));
            check("wrap_pc", w_if_id_pc, (i == 0) ? 32'hFFFF_FFFF : 32'(i - 1));
        end
        check("count4", fetch_count, 32'd4);

        // Stall while pc 5 sits in IF/ID.
        @(posedge clk);
        @(posedge clk); #1 id_ready = 1'b0;
        @(negedge clk);
        check("stall_pc", if_id_pc, 32'd5);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_pc", if_id_pc, 32'd5);
            check("stall_valid", 32'(if_id_valid), 32'd1);
            check("stall_imem_pc", imem_pc, 32'd6);
            check("stall_count", fetch_count, 32'd6);
        end
        @(posedge clk); #1 id_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_pc", if_id_pc, 32'd6);

        // Redirect beats a same-cycle stall.
        repeat (12) @(posedge clk);
        #1 id_ready = 1'b0;
        do_redirect(32'd21);
        @(negedge clk);
        check("pre_redir_imem_pc", imem_pc, 32'd19);
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_bubble", 32'(if_id_valid), 32'd0);
        check("redir_imem_pc", imem_pc, 32'd21);
        @(posedge clk);
        @(negedge clk);
        check("redir_target_pc", if_id_pc, 32'd21);
        check("redir_target_valid", 32'(if_id_valid), 32'd1);
        check("redir_count", fetch_count, 32'd20);

        // Asynchronous reset between edges.
        @(posedge clk); #1 id_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_valid", 32'(if_id_valid), 32'd0);
        check("async_pc", if_id_pc, 32'h0);
        check("async_count", fetch_count, 32'd0);
        check("async_imem_pc", imem_pc, 32'h0);
        check("async_w_imem_pc", w_imem_pc, 32'hFFFF_FFFF);
        check("async_w_valid", 32'(w_if_id_valid), 32'd0);

        // Random program image with a backward BNE at pc 12.
        for (int i = 0; i < 64; i++) begin
            logic [31:0] r;
            logic [5:0]  op;
            r = $urandom;
            if ((i % 3) == 0) begin
                case ($urandom_range(0, 4))
                    0: op = 6'b100000;
                    1: op = 6'b100001;
                    2: op = 6'b100010;
                    3: op = 6'b100011;
                    default: op = 6'b000010;
                endcase
                if ($urandom_range(0, 1) == 1) r[15:0] = 16'hFFFF - 16'($urandom_range(0, 7));
                else r[15:0] = 16'($urandom_range(0, 7));
                mem[i] = {op, r[25:0]};
            end else begin
                mem[i] = r;
            end
        end
        mem[12] = {6'b100001, 10'h0, 16'hFFFD};
        mem_mode = 1;
        @(posedge clk); #1 rst = 1'b0;
        do_redirect(32'd12);
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("bne_pc", if_id_pc, 32'd12);
        check("bne_imem_pc", imem_pc, BTFN ? 32'd10 : 32'd13);
        check("bne_pred", 32'(if_id_pred_taken), 32'(BTFN));

        // Randomized back-pressure and redirects.
        d0 = delivered;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            id_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 7) == 0) do_redirect(32'hFFFF_FFFC + 32'($urandom_range(0, 3)));
                else do_redirect(32'($urandom_range(0, 63)));
            end else begin
                redirect_valid = 1'b0;
            end
        end
        check("progress", 32'((delivered - d0) > 1000), 32'd1);

        // Counter saturation.
        @(posedge clk); #1 redirect_valid = 1'b0; id_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 id_ready = 1'b0;
        @(posedge clk); #1;
        force dut.r_fetch_count = 32'hFFFF_FFFE;
        #1 release dut.r_fetch_count;
        @(negedge clk);
        check("sat_preload", fetch_count, 32'hFFFF_FFFE);
        @(posedge clk); #1 id_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("sat_reach", fetch_count, 32'hFFFF_FFFF);
        @(posedge clk);
        @(negedge clk);
        check("sat_hold", fetch_count, 32'hFFFF_FFFF);
        check("sat_valid", 32'(if_id_valid), 32'd1);
        check("redir_q_drained", 32'(redir_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
